// File: rtl/mdr_pkg.sv
// Shared encodings for the memory data register: access sizes, FSM states and
// the alignment rule applied to every memory start.
package mdr_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10
  } state_e;

  // A start is legal only for a known size on a naturally aligned offset.
  function automatic logic req_ok(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: req_ok = 1'b1;
      SZ_HALF: req_ok = ~off[0];
      SZ_WORD: req_ok = (off == 2'b00);
      default: req_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Byte-lane steering for one access: byte-enable mask, write-data replication and
// read-data extraction with sign/zero extension.
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e                 size_i,
  input  logic [1:0]            off_i,
  input  logic                  sext_i,
  input  logic [DATA_W-1:0]     q_i,
  input  logic [DATA_W-1:0]     rdata_i,
  output logic [DATA_W/8-1:0]   be_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     rext_o
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o    = '1;
    wdata_o = q_i;
    rext_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o   = NB'(1) << off_i;
        rext_o = {{(DATA_W-8){sext_i & sh[7]}}, sh[7:0]};
        for (int i = 0; i < NB; i++) wdata_o[i*8 +: 8] = q_i[7:0];
      end
      SZ_HALF: begin
        be_o   = NB'(3) << off_i;
        rext_o = {{(DATA_W-16){sext_i & sh[15]}}, sh[15:0]};
        // Even lanes take the low byte of the half, odd lanes the high byte.
        for (int i = 0; i < NB; i++) wdata_o[i*8 +: 8] = q_i[(i%2)*8 +: 8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with a req/ack RAM port: holds the bus operand, runs one
// byte/half/word transfer at a time and flags completion, timeout or bad requests.
module mdr_mem_if
  import mdr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                MDRin,
  input  logic [DATA_W-1:0]   BusMuxOut,
  output logic [DATA_W-1:0]   BusMuxIn,
  input  logic                rd_start,
  input  logic                wr_start,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [1:0]          addr_lo,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d, err_q, err_d;
  size_e             size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              sext_q, sext_d;

  logic [DATA_W/8-1:0] al_be;
  logic [DATA_W-1:0]   al_wdata, al_rext;

  // Lane steering runs off the attributes captured at start, so the control
  // unit may change size/addr_lo/sign_ext while the transfer is in flight.
  mdr_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i  (size_q),
    .off_i   (off_q),
    .sext_i  (sext_q),
    .q_i     (q_q),
    .rdata_i (mem_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rext_o  (al_rext)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= '0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sext_q  <= sext_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    size_d  = size_q;
    off_d   = off_q;
    sext_d  = sext_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_start || wr_start) begin
          if (req_ok(size_e'(size), addr_lo)) begin
            state_d = rd_start ? ST_RD_WAIT : ST_WR_WAIT;
            cnt_d   = '0;
            size_d  = size_e'(size);
            off_d   = addr_lo;
            sext_d  = sign_ext;
          end else begin
            err_d = 1'b1;
          end
        end else if (MDRin) begin
          q_d = BusMuxOut;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // Ack is checked first so an ack on the last allowed cycle still completes.
        if (mem_ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (state_q == ST_RD_WAIT) q_d = al_rext;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = busy;
  assign mem_we    = (state_q == ST_WR_WAIT);
  assign mem_be    = busy ? al_be : '0;
  assign mem_wdata = al_wdata;
  assign done      = done_q;
  assign err       = err_q;
  assign BusMuxIn  = q_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed bench for mdr_mem_if: load, aligned reads/writes, bad starts, timeout and clear.
module tb_mdr_mem_if;
  logic        clock = 1'b0;
  logic        clear;
  logic        MDRin;
  logic [31:0] BusMuxOut, BusMuxIn;
  logic        rd_start, wr_start;
  logic [1:0]  size, addr_lo;
  logic        sign_ext;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  mdr_mem_if #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .MDRin(MDRin), .BusMuxOut(BusMuxOut),
    .BusMuxIn(BusMuxIn), .rd_start(rd_start), .wr_start(wr_start), .size(size),
    .sign_ext(sign_ext), .addr_lo(addr_lo), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Start a transfer, ack on request cycle ack_cyc (0 = never), check outcome.
  task automatic xfer(input string tag, input logic rd, input logic [1:0] sz,
                      input logic [1:0] off, input logic sx, input logic [31:0] rdata,
                      input int ack_cyc, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic exp_done,
                      input logic [31:0] exp_q);
    int c;
    rd_start = rd; wr_start = ~rd; size = sz; addr_lo = off; sign_ext = sx;
    mem_rdata = rdata;
    @(negedge clock);
    rd_start = 0; wr_start = 0;
    chk({tag, " req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, " we"}, {31'd0, mem_we}, {31'd0, ~rd});
    chk({tag, " be"}, {28'd0, mem_be}, {28'd0, exp_be});
    if (!rd) chk({tag, " wdata"}, mem_wdata, exp_wd);
    c = 1;
    while (mem_req && c < 40) begin
      mem_ack = (c == ack_cyc);
      @(negedge clock);
      mem_ack = 0;
      c++;
    end
    chk({tag, " done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, " err"}, {31'd0, err}, {31'd0, ~exp_done});
    chk({tag, " req cycles"}, 32'(c - 1), (ack_cyc == 0) ? 32'd15 : 32'(ack_cyc));
    @(negedge clock);
    chk({tag, " pulse end"}, {30'd0, done, err}, 32'd0);
    chk({tag, " q"}, BusMuxIn, exp_q);
  endtask

  // Illegal/misaligned read start: err pulse, no request, q untouched.
  task automatic bad_start(input string tag, input logic [1:0] sz, input logic [1:0] off,
                           input logic [31:0] exp_q);
    rd_start = 1; size = sz; addr_lo = off; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    rd_start = 0;
    chk({tag, " req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd1);
    @(negedge clock);
    chk({tag, " err end"}, {30'd0, err, mem_req}, 32'd0);
    chk({tag, " q"}, BusMuxIn, exp_q);
  endtask

  initial begin
    clear = 1; MDRin = 0; BusMuxOut = 0; rd_start = 0; wr_start = 0;
    size = 0; addr_lo = 0; sign_ext = 0; mem_rdata = 0; mem_ack = 0;
    @(negedge clock);
    chk("rst outs", {26'd0, mem_req, mem_we, busy, done, err, 1'b0}, 32'd0);
    chk("rst be", {28'd0, mem_be}, 32'd0);
    chk("rst q", BusMuxIn, 32'd0);
    clear = 0;

    MDRin = 1; BusMuxOut = 32'hDEADBEEF;
    @(negedge clock);
    MDRin = 0;
    chk("load", BusMuxIn, 32'hDEADBEEF);

    xfer("wr word", 0, 2'b10, 2'd0, 0, 32'h0,        2, 4'hF, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    xfer("rd b3 s", 1, 2'b00, 2'd3, 1, 32'h80123456, 1, 4'h8, 32'h0,        1, 32'hFFFFFF80);
    xfer("rd b3 z", 1, 2'b00, 2'd3, 0, 32'h80123456, 1, 4'h8, 32'h0,        1, 32'h00000080);
    xfer("rd h2 s", 1, 2'b01, 2'd2, 1, 32'h7FFF0000, 1, 4'hC, 32'h0,        1, 32'h00007FFF);
    xfer("rd h0 s", 1, 2'b01, 2'd0, 1, 32'h12348001, 3, 4'h3, 32'h0,        1, 32'hFFFF8001);
    xfer("wr b1",   0, 2'b00, 2'd1, 0, 32'h0,        3, 4'h2, 32'h01010101, 1, 32'hFFFF8001);
    xfer("wr h2",   0, 2'b01, 2'd2, 0, 32'h0,        1, 4'hC, 32'h80018001, 1, 32'hFFFF8001);
    xfer("tmo",     1, 2'b10, 2'd0, 0, 32'h55555555, 0, 4'hF, 32'h0,        0, 32'hFFFF8001);
    xfer("ack15",   1, 2'b10, 2'd0, 0, 32'h0BADF00D, 15, 4'hF, 32'h0,       1, 32'h0BADF00D);

    bad_start("bad h1", 2'b01, 2'd1, 32'h0BADF00D);
    bad_start("bad w2", 2'b10, 2'd2, 32'h0BADF00D);
    bad_start("bad sz", 2'b11, 2'd0, 32'h0BADF00D);

    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clock);
    mem_ack = 0;
    chk("idle ack", {29'd0, done, err, mem_req}, 32'd0);
    chk("idle ack q", BusMuxIn, 32'h0BADF00D);

    rd_start = 1; wr_start = 1; size = 2'b10; addr_lo = 0;
    @(negedge clock);
    rd_start = 0; wr_start = 0; MDRin = 1; BusMuxOut = 32'hCAFEF00D;
    chk("prio we", {30'd0, mem_req, mem_we}, 32'd2);
    @(negedge clock);
    MDRin = 0;
    chk("mdrin in wait", BusMuxIn, 32'h0BADF00D);
    clear = 1;
    #1;
    chk("clr mid", {30'd0, mem_req, busy}, 32'd0);
    chk("clr q", BusMuxIn, 32'd0);
    @(negedge clock);
    clear = 0;
    @(negedge clock);
    chk("post clr", {29'd0, mem_req, done, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
